instr_decode_stage: RTL and testbench

Parametrised fetch-to-execute decode stage for the 9-bit CPU family, generalised in instruction, opcode, operand and literal widths and in register-bank count. Splits each instruction into opcode and operand and handles three stateful cases: litl/lith fusion into one literal, seth register-bank prefix, and func/done halt. Sits between the instruction fetch unit and the execute/register-file stage, with valid/ready handshakes on both sides.

---
 rtl/instr_decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Decode stage between instruction fetch and execute for the 9-bit CPU family.
// Splits each instruction into opcode and operand, fuses litl/lith pairs into
// one literal, applies seth bank prefixes and latches the func/done halt.
// A litl followed by anything other than lith is emitted on its own, and the
// following instruction is parked in a one-entry replay slot until the output
// register frees up.
module instr_decode_stage #(
    parameter int OPC_W   = 5,
    parameter int ARG_W   = 4,
    parameter int INSTR_W = 9,
    parameter int BANKS   = 2,
    parameter int LIT_W   = 8,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPC_W-1:0]        out_op,
    output logic [ARG_W+BANK_W-1:0] out_reg,
    output logic [LIT_W-1:0]        out_lit,
    output logic                    out_fused,
    output logic                    halted
);

    // Parameter sanity: field layout and bank encoding must be consistent.
    if (INSTR_W != OPC_W + ARG_W) begin : g_bad_instr_w
        $error("instr_decode_stage: INSTR_W must equal OPC_W + ARG_W");
    end
    if (LIT_W != 2 * ARG_W) begin : g_bad_lit_w
        $error("instr_decode_stage: LIT_W must equal 2 * ARG_W");
    end
    if ((BANKS < 1) || ((BANKS & (BANKS - 1)) != 0)) begin : g_bad_banks
        $error("instr_decode_stage: BANKS must be a power of two and >= 1");
    end
    if (BANK_W > ARG_W) begin : g_bad_bank_w
        $error("instr_decode_stage: bank index does not fit in the operand field");
    end

    localparam logic [OPC_W-1:0] OPC_LITL = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_LITH = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_SETH = OPC_W'(25);
    localparam logic [OPC_W-1:0] OPC_FUNC = OPC_W'(31);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ARG_W-1:0]          held_q, held_d;
    logic [INSTR_W-1:0]        replay_q, replay_d;
    logic [BANK_W-1:0]         bank_q, bank_d;
    logic                      halted_q, halted_d;
    logic                      out_valid_q, out_valid_d;
    logic [OPC_W-1:0]          out_op_q, out_op_d;
    logic [ARG_W+BANK_W-1:0]   out_reg_q, out_reg_d;
    logic [LIT_W-1:0]          out_lit_q, out_lit_d;
    logic                      out_fused_q, out_fused_d;

    logic                      slot_free;
    logic                      accept;
    logic                      fresh_go;
    logic [INSTR_W-1:0]        fresh_instr;
    logic [OPC_W-1:0]          fresh_op;
    logic [ARG_W-1:0]          fresh_arg;
    logic [OPC_W-1:0]          in_op;
    logic [ARG_W-1:0]          in_arg;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q != ST_REPLAY) && !halted_q && slot_free;
    assign accept    = in_valid && in_ready && !flush;

    // Instruction decoded "as from IDLE": the parked one while replaying, else the fetched one.
    assign fresh_instr = (state_q == ST_REPLAY) ? replay_q : in_instr;
    assign fresh_op    = fresh_instr[INSTR_W-1 -: OPC_W];
    assign fresh_arg   = fresh_instr[ARG_W-1:0];
    assign in_op       = in_instr[INSTR_W-1 -: OPC_W];
    assign in_arg      = in_instr[ARG_W-1:0];

    // Next-state selection: flush, then replay drain, then newly accepted instruction.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        replay_d    = replay_q;
        bank_d      = bank_q;
        halted_d    = halted_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_reg_d   = out_reg_q;
        out_lit_d   = out_lit_q;
        out_fused_d = out_fused_q;
        fresh_go    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else if ((state_q == ST_REPLAY) && slot_free) begin
            fresh_go = 1'b1;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: fresh_go = 1'b1;
                ST_HELD: begin
                    out_valid_d = 1'b1;
                    if (in_op == OPC_LITH) begin
                        out_op_d    = OPC_LITH;
                        out_reg_d   = {bank_q, in_arg};
                        out_lit_d   = {in_arg, held_q};
                        out_fused_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        // The pending litl leaves alone; the newcomer is either
                        // the next held nibble or parked for replay.
                        out_op_d    = OPC_LITL;
                        out_reg_d   = {bank_q, held_q};
                        out_lit_d   = LIT_W'(held_q);
                        out_fused_d = 1'b0;
                        if (in_op == OPC_LITL) begin
                            held_d = in_arg;
                        end else begin
                            replay_d = in_instr;
                            state_d  = ST_REPLAY;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (fresh_go) begin
            state_d = ST_IDLE;
            if (fresh_op == OPC_LITL) begin
                held_d  = fresh_arg;
                state_d = ST_HELD;
            end else if (fresh_op == OPC_SETH) begin
                bank_d = (BANKS > 1) ? fresh_arg[BANK_W-1:0] : '0;
            end else begin
                out_valid_d = 1'b1;
                out_op_d    = fresh_op;
                out_reg_d   = {bank_q, fresh_arg};
                out_lit_d   = LIT_W'(fresh_arg);
                out_fused_d = 1'b0;
                if ((fresh_op == OPC_FUNC) && (&fresh_arg)) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    // State and output registers; everything is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            replay_q    <= '0;
            bank_q      <= '0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_reg_q   <= '0;
            out_lit_q   <= '0;
            out_fused_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            replay_q    <= replay_d;
            bank_q      <= bank_d;
            halted_q    <= halted_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_reg_q   <= out_reg_d;
            out_lit_q   <= out_lit_d;
            out_fused_q <= out_fused_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_reg   = out_reg_q;
    assign out_lit   = out_lit_q;
    assign out_fused = out_fused_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios followed by a randomized
// run, with every emitted bundle compared against a stream-level model.
module tb_instr_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_instr = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_op;
    logic [4:0] out_reg;
    logic [7:0] out_lit;
    logic       out_fused;
    logic       halted;

    instr_decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_reg   (out_reg),
        .out_lit   (out_lit),
        .out_fused (out_fused),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [4:0] rg;
        logic [7:0] lit;
        bit         fused;
        bit         chkreg;
    } bundle_t;

    bundle_t    exp_q[$];
    bit         m_held_v = 1'b0;
    logic [3:0] m_held = '0;
    bit         m_bank = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic       s_ir, s_ov, s_fused, s_halt;
    logic [4:0] s_op, s_rg;
    logic [7:0] s_lit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [4:0] op, input logic [4:0] rg, input logic [7:0] lit,
                        input bit fused, input bit chkreg);
        bundle_t b;
        b.op = op; b.rg = rg; b.lit = lit; b.fused = fused; b.chkreg = chkreg;
        exp_q.push_back(b);
    endtask

    // Stream rules: a pending litl either fuses with lith or leaves alone
    // before the newcomer is handled; seth retargets the bank; others emit.
    task automatic model_feed(input logic [8:0] ins);
        logic [4:0] op;
        logic [3:0] a;
        op = ins[8:4];
        a  = ins[3:0];
        if (m_held_v) begin
            m_held_v = 1'b0;
            if (op == 5'd1) begin
                push(5'd1, 5'd0, {a, m_held}, 1'b1, 1'b0);
                return;
            end
            push(5'd0, 5'd0, {4'h0, m_held}, 1'b0, 1'b0);
        end
        if (op == 5'd0) begin
            m_held   = a;
            m_held_v = 1'b1;
        end else if (op == 5'd25) begin
            m_bank = a[0];
        end else begin
            push(op, {m_bank, a}, {4'h0, a}, 1'b0, 1'b1);
        end
    endtask

    task automatic consume();
        bundle_t b;
        $display("bundle op=%0d reg=%02h lit=%02h fused=%0d", s_op, s_rg, s_lit, s_fused);
        chk("bundle_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("bundle_op", s_op, b.op);
            chk("bundle_lit", s_lit, b.lit);
            chk("bundle_fused", s_fused, b.fused);
            if (b.chkreg) chk("bundle_reg", s_rg, b.rg);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, update model at the rising edge.
    task automatic cyc(input bit v, input logic [8:0] ins, input bit ordy, input bit fl);
        bit acc;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = 1'b0;
        #1;
        s_ir = in_ready; s_ov = out_valid; s_op = out_op; s_rg = out_reg;
        s_lit = out_lit; s_fused = out_fused; s_halt = halted;
        // flush is only raised while the stage could accept, never mid-replay
        flush = fl && s_ir;
        if (s_ov && ordy) consume();
        acc = v && s_ir && !flush;
        @(posedge clk);
        if (acc) model_feed(ins);
        if (flush) begin
            exp_q.delete();
            m_held_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {out_op, out_reg, out_lit, out_fused}, 0);
        exp_q.delete();
        m_held_v = 1'b0;
        m_bank   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [8:0] rand_instr();
        int unsigned r;
        logic [3:0]  a;
        logic [4:0]  op;
        r  = $urandom_range(0, 9);
        a  = 4'($urandom_range(0, 15));
        if (r <= 2)      op = 5'd0;
        else if (r <= 4) op = 5'd1;
        else if (r == 5) op = 5'd25;
        else if (r == 6) begin
            op = 5'd31;
            a  = 4'($urandom_range(0, 14));
        end else op = 5'($urandom_range(2, 24));
        return {op, a};
    endfunction

    initial begin
        @(negedge clk);
        do_reset();

        // litl + lith fuse into a single bundle one cycle after the lith
        cyc(1, 9'h005, 1, 0);  chk("fuse_ir", s_ir, 1);
        cyc(1, 9'h01A, 1, 0);  chk("fuse_no_early_out", s_ov, 0);
        cyc(0, 9'h000, 1, 0);
        chk("fuse_valid", s_ov, 1); chk("fuse_op", s_op, 1);
        chk("fuse_lit", s_lit, 8'hA5); chk("fuse_fused", s_fused, 1);
        cyc(0, 9'h000, 1, 0);  chk("fuse_single", s_ov, 0);

        // orphan litl followed by movx goes through the replay slot
        cyc(1, 9'h005, 1, 0);
        cyc(1, 9'h063, 1, 0);  chk("orphan_accept", s_ir, 1);
        cyc(0, 9'h000, 1, 0);
        chk("orphan_replay_ir", s_ir, 0); chk("orphan_b1_valid", s_ov, 1);
        chk("orphan_b1_op", s_op, 0); chk("orphan_b1_lit", s_lit, 8'h05);
        chk("orphan_b1_fused", s_fused, 0);
        cyc(0, 9'h000, 1, 0);
        chk("orphan_b2_valid", s_ov, 1); chk("orphan_b2_op", s_op, 6);
        chk("orphan_b2_reg", s_rg, 5'h03); chk("orphan_ir_back", s_ir, 1);

        // seth selects bank 1 and emits nothing
        cyc(1, 9'h191, 1, 0);
        cyc(1, 9'h063, 1, 0);  chk("seth_no_bundle", s_ov, 0);
        cyc(0, 9'h000, 1, 0);  chk("seth_valid", s_ov, 1); chk("seth_reg", s_rg, 5'h13);
        cyc(0, 9'h000, 1, 0);  chk("seth_single", s_ov, 0);

        // backpressure holds the bundle and blocks fetch
        cyc(1, 9'h063, 1, 0);
        repeat (3) begin
            cyc(1, 9'h0A2, 0, 0);
            chk("bp_valid", s_ov, 1); chk("bp_op", s_op, 6);
            chk("bp_reg", s_rg, 5'h13); chk("bp_ir", s_ir, 0);
        end
        cyc(1, 9'h0A2, 1, 0);  chk("bp_release_ir", s_ir, 1);
        cyc(0, 9'h000, 1, 0);  chk("bp_next_op", s_op, 5'd10); chk("bp_next_reg", s_rg, 5'h12);

        // flush drops the held litl and refuses the presented lith
        cyc(1, 9'h005, 1, 0);
        cyc(1, 9'h01A, 1, 1);
        cyc(0, 9'h000, 1, 0);  chk("flush_no_bundle", s_ov, 0);
        cyc(1, 9'h01A, 1, 0);
        cyc(0, 9'h000, 1, 0);
        chk("flush_op", s_op, 1); chk("flush_lit", s_lit, 8'h0A);
        chk("flush_fused", s_fused, 0); chk("flush_reg", s_rg, 5'h1A);

        // reset in HELD loses the nibble and the bank
        cyc(1, 9'h005, 1, 0);
        do_reset();
        cyc(1, 9'h01A, 1, 0);
        cyc(0, 9'h000, 1, 0);
        chk("rstmid_fused", s_fused, 0); chk("rstmid_lit", s_lit, 8'h0A);
        chk("rstmid_reg", s_rg, 5'h0A);

        // randomized traffic with backpressure and occasional flushes
        repeat (600) begin
            cyc(1'($urandom_range(0, 1)), rand_instr(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 29) == 0);
        end
        repeat (8) cyc(0, 9'h000, 1, 0);
        chk("drain_empty", exp_q.size(), 0);

        // done halts the stage; reset clears halted and bank
        do_reset();
        cyc(1, 9'h191, 1, 0);
        cyc(1, 9'h1FF, 1, 0);
        cyc(1, 9'h063, 0, 0);
        chk("halt_valid", s_ov, 1); chk("halt_op", s_op, 31);
        chk("halt_reg", s_rg, 5'h1F); chk("halt_flag", s_halt, 1);
        chk("halt_ir", s_ir, 0);
        cyc(1, 9'h063, 1, 0);  chk("halt_drain_valid", s_ov, 1); chk("halt_drain_ir", s_ir, 0);
        cyc(1, 9'h063, 1, 0);
        chk("halt_empty", s_ov, 0); chk("halt_ir_stuck", s_ir, 0); chk("halt_sticky", s_halt, 1);
        do_reset();
        cyc(1, 9'h063, 1, 0);
        cyc(0, 9'h000, 1, 0);
        chk("post_halt_valid", s_ov, 1); chk("post_halt_reg", s_rg, 5'h03);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
